// File: rtl/inta_sequencer.sv
// CPU-side interrupt-acknowledge initiator: issues the two-pulse INTA sequence,
// captures the PIC vector on the second pulse and holds it until the core takes it.
module inta_sequencer #(
    parameter int PULSE_LEN = 2,
    parameter int GAP_LEN   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       intr,
    input  logic       en,
    input  logic [7:0] data_in,
    input  logic       core_ready,
    output logic       inta_n,
    output logic [7:0] vector,
    output logic       vector_valid,
    output logic       busy
);

    localparam logic [3:0] PULSE_CNT = 4'(PULSE_LEN);
    localparam logic [3:0] GAP_CNT   = 4'(GAP_LEN);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        P1   = 3'd1,
        GAP  = 3'd2,
        P2   = 3'd3,
        HOLD = 3'd4,
        LOCK = 3'd5
    } state_t;

    state_t     state_reg, state_next;
    logic [3:0] cnt_reg, cnt_next;
    logic [7:0] vector_reg, vector_next;
    logic       vector_valid_reg, vector_valid_next;
    logic       inta_n_reg, inta_n_next;
    logic       busy_reg, busy_next;

    // A timed state ends on the cycle its count reaches 1 (loaded with its length on entry).
    logic cnt_expired;
    assign cnt_expired = (cnt_reg <= 4'd1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg        <= IDLE;
            cnt_reg          <= 4'd0;
            vector_reg       <= 8'h00;
            vector_valid_reg <= 1'b0;
            inta_n_reg       <= 1'b1;
            busy_reg         <= 1'b0;
        end else begin
            state_reg        <= state_next;
            cnt_reg          <= cnt_next;
            vector_reg       <= vector_next;
            vector_valid_reg <= vector_valid_next;
            inta_n_reg       <= inta_n_next;
            busy_reg         <= busy_next;
        end
    end

    always_comb begin
        state_next        = state_reg;
        cnt_next          = cnt_reg;
        vector_next       = vector_reg;
        vector_valid_next = vector_valid_reg;

        case (state_reg)
            IDLE: begin
                if (intr && en) begin
                    state_next = P1;
                    cnt_next   = PULSE_CNT;
                end
            end
            P1: begin
                if (cnt_expired) begin
                    state_next = GAP;
                    cnt_next   = GAP_CNT;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            GAP: begin
                if (cnt_expired) begin
                    state_next = P2;
                    cnt_next   = PULSE_CNT;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            P2: begin
                // The vector is taken on the edge that ends the last low cycle.
                if (cnt_expired) begin
                    state_next        = HOLD;
                    cnt_next          = 4'd0;
                    vector_next       = data_in;
                    vector_valid_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            HOLD: begin
                if (core_ready) begin
                    state_next        = LOCK;
                    cnt_next          = GAP_CNT;
                    vector_valid_next = 1'b0;
                end
            end
            LOCK: begin
                if (cnt_expired) begin
                    state_next = IDLE;
                    cnt_next   = 4'd0;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 4'd0;
            end
        endcase

        // Outputs are registered from the next state so they line up with the state register.
        inta_n_next = !((state_next == P1) || (state_next == P2));
        busy_next   = (state_next != IDLE);
    end

    assign inta_n       = inta_n_reg;
    assign vector       = vector_reg;
    assign vector_valid = vector_valid_reg;
    assign busy         = busy_reg;

endmodule

// File: tb/tb_inta_sequencer.sv
// Randomized scoreboard bench for inta_sequencer: two configurations driven by the
// same stimulus, each checked cycle by cycle against an arithmetic timing model.
module tb_inta_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       intr = 1'b0;
    logic       en = 1'b0;
    logic       core_ready = 1'b0;
    logic [7:0] data_in = 8'h00;

    int errors = 0;
    int checks = 0;
    int ecount = 0;   // number of rising edges so far; cycle c lies between edge c-1 and edge c

    always #5 clk = ~clk;
    always @(posedge clk) ecount <= ecount + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        localparam int P = (gi == 0) ? 2 : 1;
        localparam int G = (gi == 0) ? 2 : 4;

        logic       inta_n, vector_valid, busy;
        logic [7:0] vector;

        inta_sequencer #(.PULSE_LEN(P), .GAP_LEN(G)) dut (
            .clk(clk),
            .reset(reset),
            .intr(intr),
            .en(en),
            .data_in(data_in),
            .core_ready(core_ready),
            .inta_n(inta_n),
            .vector(vector),
            .vector_valid(vector_valid),
            .busy(busy)
        );

        // Model: mode 0 = free/locked out, 1 = sequence started at edge s, 2 = vector waiting.
        int         mode = 0;
        int         s = 0;
        int         next_ok = 0;
        logic [7:0] exp_q[$];
        logic [7:0] held = 8'h00;
        logic       vv_prev = 1'b0;

        always @(posedge clk or posedge reset) begin
            if (reset) begin
                mode    <= 0;
                next_ok <= ecount + 1;
                exp_q.delete();
            end else if (mode == 0) begin
                if (ecount >= next_ok && intr && en) begin
                    mode <= 1;
                    s    <= ecount;
                end
            end else if (mode == 1) begin
                if (ecount == s + 2*P + G) begin
                    mode <= 2;
                    exp_q.push_back(data_in);
                end
            end else if (core_ready) begin
                mode    <= 0;
                next_ok <= ecount + G + 1;
            end
        end

        always @(negedge clk) begin
            int         c;
            logic       exp_low, exp_busy, exp_vv;
            logic [7:0] want;
            c        = ecount;
            exp_low  = !reset && mode == 1 &&
                       ((c >= s + 1 && c <= s + P) || (c >= s + P + G + 1 && c <= s + 2*P + G));
            exp_busy = !reset && (mode != 0 || c < next_ok);
            exp_vv   = !reset && mode == 2;
            check($sformatf("cfg%0d inta_n", gi), 32'(inta_n), 32'(!exp_low));
            check($sformatf("cfg%0d busy", gi), 32'(busy), 32'(exp_busy));
            check($sformatf("cfg%0d vector_valid", gi), 32'(vector_valid), 32'(exp_vv));
            if (vector_valid && !vv_prev) begin
                if (exp_q.size() == 0) begin
                    check($sformatf("cfg%0d scoreboard_empty", gi), 32'(exp_q.size()), 32'd1);
                end else begin
                    want = exp_q.pop_front();
                    check($sformatf("cfg%0d vector", gi), 32'(vector), 32'(want));
                    held <= want;
                end
            end else if (vector_valid) begin
                check($sformatf("cfg%0d vector_held", gi), 32'(vector), 32'(held));
            end
            vv_prev <= vector_valid;
        end
    end

    task automatic release_reset();
        @(negedge clk);
        #2 reset = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset inta_n", 32'(g_dut[0].inta_n), 32'd1);
        check("reset vector", 32'(g_dut[0].vector), 32'h00);
        check("reset vector_valid", 32'(g_dut[0].vector_valid), 32'd0);
        check("reset busy", 32'(g_dut[1].busy), 32'd0);
        release_reset();

        // Basic sequence with the core always ready.
        @(negedge clk);
        intr = 1'b1; en = 1'b1; core_ready = 1'b1; data_in = 8'h4A;
        repeat (8) @(negedge clk);
        intr = 1'b0;
        repeat (8) @(negedge clk);

        // Enable gating, then a held vector while the core is not ready.
        intr = 1'b1; en = 1'b0; core_ready = 1'b0; data_in = 8'h21;
        repeat (20) @(negedge clk);
        check("gated inta_n", 32'(g_dut[0].inta_n), 32'd1);
        check("gated busy", 32'(g_dut[0].busy), 32'd0);
        en = 1'b1;
        @(negedge clk);
        intr = 1'b0;
        repeat (8) @(negedge clk);
        data_in = 8'hFF;
        repeat (10) @(negedge clk);
        check("held vector", 32'(g_dut[0].vector), 32'h21);
        check("held vector_valid", 32'(g_dut[0].vector_valid), 32'd1);
        core_ready = 1'b1;
        @(negedge clk);
        core_ready = 1'b0;
        repeat (8) @(negedge clk);

        // Request withdrawn during the gap: the second pulse must still be issued.
        core_ready = 1'b1; intr = 1'b1; data_in = 8'h00;
        @(negedge clk);
        repeat (3) @(negedge clk);
        intr = 1'b0; data_in = 8'h27;
        repeat (10) @(negedge clk);

        // Asynchronous reset in the middle of P2.
        intr = 1'b1; data_in = 8'h55;
        @(negedge clk);
        repeat (5) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("midreset inta_n", 32'(g_dut[0].inta_n), 32'd1);
        check("midreset vector_valid", 32'(g_dut[0].vector_valid), 32'd0);
        check("midreset vector", 32'(g_dut[0].vector), 32'h00);
        release_reset();
        repeat (6) @(negedge clk);
        intr = 1'b0;
        repeat (12) @(negedge clk);

        // Randomized traffic, including long stretches of held intr and occasional resets.
        repeat (3000) begin
            @(negedge clk);
            intr       = ($urandom_range(0, 3) != 0);
            en         = ($urandom_range(0, 7) != 0);
            core_ready = ($urandom_range(0, 2) != 0);
            data_in    = 8'($urandom);
            if ($urandom_range(0, 499) == 0) begin
                #2 reset = 1'b1;
                release_reset();
            end
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
